// File: rtl/synth_pkg.sv
// Shared synth definitions: scheduler state encoding and register address map.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam logic [7:0] ADRS_NOTE       = 8'h01;
  localparam logic [7:0] ADRS_CTRL       = 8'h11;
  localparam logic [7:0] ADRS_PARAM_BASE = 8'h80;

endpackage

// File: rtl/synth_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module synth_rr_pick #(
  parameter int NREQ = 4,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/synth_wr_sched.sv
// Round-robin scheduler for the single synth register-write port.
// Build option SYNTH_WR_SCHED_PRIO0_EN: requester 0 becomes strict priority over the rotating rest.
module synth_wr_sched
  import synth_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int ADRS_W   = 8,
  parameter int DATA_W   = 8,
  parameter int WREQ_CYC = 2,
  parameter int GAP_CYC  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADRS_W-1:0]   req_adrs,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     fifo_full,
  output logic                     wreq,
  output logic [ADRS_W-1:0]        memadrs,
  output logic [DATA_W-1:0]        memdata,
  output logic                     busy
);

  localparam int PTR_W   = $clog2(NREQ);
  localparam int CNT_MAX = (WREQ_CYC > GAP_CYC) ? WREQ_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WREQ_LAST = CNT_W'(WREQ_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NREQ - 1);

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_nxt;

  logic [NREQ-1:0]  pick_req, pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;

  logic [NREQ-1:0]  win_onehot;
  logic [PTR_W-1:0] win_idx;
  logic             win_vld;
  logic             ptr_adv;
  logic             launch;

  synth_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (pick_req),
    .rr_ptr (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

`ifdef SYNTH_WR_SCHED_PRIO0_EN
  // Requester 0 bypasses the rotation and leaves rr_ptr untouched when it wins.
  assign pick_req = {req[NREQ-1:1], 1'b0};

  always_comb begin
    win_onehot = pick_onehot;
    win_idx    = pick_idx;
    win_vld    = pick_vld;
    ptr_adv    = 1'b1;
    if (req[0]) begin
      win_onehot = NREQ'(1);
      win_idx    = '0;
      win_vld    = 1'b1;
      ptr_adv    = 1'b0;
    end
  end
`else
  assign pick_req   = req;
  assign win_onehot = pick_onehot;
  assign win_idx    = pick_idx;
  assign win_vld    = pick_vld;
  assign ptr_adv    = 1'b1;
`endif

  assign launch = (state == IDLE) && win_vld && !fifo_full;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = ISSUE;
          cnt_nxt   = '0;
          if (ptr_adv) rr_nxt = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
        end
      end
      ISSUE: begin
        if (cnt == WREQ_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Address/data are captured in the decision cycle so the requester is free after gnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt     <= '0;
      memadrs <= '0;
      memdata <= '0;
    end else begin
      gnt <= launch ? win_onehot : '0;
      if (launch) begin
        memadrs <= req_adrs[win_idx*ADRS_W +: ADRS_W];
        memdata <= req_data[win_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign wreq = (state == ISSUE);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_synth_wr_sched.sv
// Directed bench for synth_wr_sched: vector table for single writes plus hand-written corner sequences.
module tb_synth_wr_sched;
  import synth_pkg::*;

  localparam int NREQ     = 4;
  localparam int ADRS_W   = 8;
  localparam int DATA_W   = 8;
  localparam int WREQ_CYC = 2;
  localparam int GAP_CYC  = 16;
  localparam int SPACING  = WREQ_CYC + GAP_CYC + 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADRS_W-1:0] req_adrs;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   fifo_full;
  logic                   wreq;
  logic [ADRS_W-1:0]      memadrs;
  logic [DATA_W-1:0]      memdata;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;

  synth_wr_sched #(
    .NREQ(NREQ), .ADRS_W(ADRS_W), .DATA_W(DATA_W),
    .WREQ_CYC(WREQ_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_adrs(req_adrs), .req_data(req_data),
    .gnt(gnt), .fifo_full(fifo_full), .wreq(wreq), .memadrs(memadrs),
    .memdata(memdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] adrs;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_adrs;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Issue one vector from idle and follow the full write through ISSUE and GAP.
  task automatic run_vec(input vec_t v, input int k);
    req      = v.req;
    req_adrs = v.adrs;
    req_data = v.data;
    @(negedge clk);
    chk($sformatf("v%0d_gnt", k), {28'd0, gnt}, {28'd0, v.exp_gnt});
    chk($sformatf("v%0d_wreq_c1", k), {31'd0, wreq}, 32'd1);
    chk($sformatf("v%0d_adrs", k), {24'd0, memadrs}, {24'd0, v.exp_adrs});
    chk($sformatf("v%0d_data", k), {24'd0, memdata}, {24'd0, v.exp_data});
    chk($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd1);
    req      = '0;
    req_adrs = ~v.adrs;
    req_data = ~v.data;
    @(negedge clk);
    chk($sformatf("v%0d_gnt_pulse", k), {28'd0, gnt}, 32'd0);
    chk($sformatf("v%0d_wreq_c2", k), {31'd0, wreq}, 32'd1);
    chk($sformatf("v%0d_adrs_hold", k), {24'd0, memadrs}, {24'd0, v.exp_adrs});
    chk($sformatf("v%0d_data_hold", k), {24'd0, memdata}, {24'd0, v.exp_data});
    @(negedge clk);
    chk($sformatf("v%0d_wreq_off", k), {31'd0, wreq}, 32'd0);
    chk($sformatf("v%0d_gap_busy", k), {31'd0, busy}, 32'd1);
    repeat (GAP_CYC - 1) @(negedge clk);
    chk($sformatf("v%0d_gap_end_busy", k), {31'd0, busy}, 32'd1);
    chk($sformatf("v%0d_gap_adrs", k), {24'd0, memadrs}, {24'd0, v.exp_adrs});
    @(negedge clk);
    chk($sformatf("v%0d_idle", k), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rr_ptr evolves 0 -> 3 -> 1 -> 0 -> 2 -> 3 across the table.
    vecs[0] = '{4'b0100, {8'h00, ADRS_CTRL, 8'h00, 8'h00}, 32'h005A0000, 4'b0100, 8'h11, 8'h5A};
    vecs[1] = '{4'b0011, {8'h33, 8'h22, 8'h11, ADRS_NOTE}, 32'hD3D2D1C3, 4'b0001, 8'h01, 8'hC3};
    vecs[2] = '{4'b1001, {8'h87, 8'h22, 8'h11, 8'h01}, 32'hFF000000, 4'b1000, 8'h87, 8'hFF};
    vecs[3] = '{4'b0110, {8'h83, 8'h82, 8'h81, ADRS_PARAM_BASE}, 32'h04030201, 4'b0010, 8'h81, 8'h02};
    vecs[4] = '{4'b1111, {8'h83, 8'h82, 8'h81, ADRS_PARAM_BASE}, 32'h04030201, 4'b0100, 8'h82, 8'h03};

    reset     = 1'b1;
    req       = '0;
    req_adrs  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_wreq", {31'd0, wreq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_adrs", {24'd0, memadrs}, 32'd0);
    chk("rst_data", {24'd0, memdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset during ISSUE abandons the write; the still-pending request then gets a full write.
    req      = 4'b0010;
    req_adrs = 32'h44332211;
    req_data = 32'h99887766;
    @(negedge clk);
    chk("t1_gnt", {28'd0, gnt}, 32'h2);
    chk("t1_wreq", {31'd0, wreq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_wreq", {31'd0, wreq}, 32'd0);
    chk("t1_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("t1_rst_busy", {31'd0, busy}, 32'd0);
    chk("t1_rst_adrs", {24'd0, memadrs}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t1_regnt", {28'd0, gnt}, 32'h2);
    chk("t1_readrs", {24'd0, memadrs}, 32'h22);
    chk("t1_redata", {24'd0, memdata}, 32'h77);
    req = '0;
    @(negedge clk);
    chk("t1_wreq_c2", {31'd0, wreq}, 32'd1);
    @(negedge clk);
    chk("t1_wreq_off", {31'd0, wreq}, 32'd0);
    wait_idle(40);

`ifndef SYNTH_WR_SCHED_PRIO0_EN
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Full contention from rr_ptr=0: strict rotation with fixed spacing.
    do_reset();
    req = 4'b1111;
    begin
      int cyc;
      int last;
      logic [3:0] e;
      cyc  = 0;
      last = 0;
      for (int g = 0; g < 5; g++) begin
        int k;
        k = 0;
        do begin
          @(negedge clk);
          cyc++;
          k++;
        end while (gnt == '0 && k < 40);
        e = 4'(1 << (g % 4));
        chk($sformatf("t3_order%0d", g), {28'd0, gnt}, {28'd0, e});
        if (g > 0) chk($sformatf("t3_space%0d", g), 32'(cyc - last), 32'(SPACING));
        last = cyc;
      end
    end
    req = '0;
    wait_idle(40);

    // Backpressure in IDLE blocks the grant until fifo_full drops.
    fifo_full = 1'b1;
    req       = 4'b0010;
    req_adrs  = 32'h00005500;
    req_data  = 32'h0000AA00;
    repeat (4) begin
      @(negedge clk);
      chk("t4_hold_gnt", {28'd0, gnt}, 32'd0);
      chk("t4_hold_busy", {31'd0, busy}, 32'd0);
    end
    fifo_full = 1'b0;
    @(negedge clk);
    chk("t4_gnt", {28'd0, gnt}, 32'h2);
    chk("t4_adrs", {24'd0, memadrs}, 32'h55);
    req = '0;
    wait_idle(40);

    // fifo_full during ISSUE does not cut the write short but blocks the next grant.
    req      = 4'b1000;
    req_adrs = 32'hAB0000CD;
    req_data = 32'h120000EF;
    @(negedge clk);
    chk("t5_gnt", {28'd0, gnt}, 32'h8);
    fifo_full = 1'b1;
    req       = 4'b0001;
    chk("t5_wreq_c1", {31'd0, wreq}, 32'd1);
    @(negedge clk);
    chk("t5_wreq_c2", {31'd0, wreq}, 32'd1);
    chk("t5_adrs", {24'd0, memadrs}, 32'hAB);
    @(negedge clk);
    chk("t5_wreq_off", {31'd0, wreq}, 32'd0);
    chk("t5_gap_busy", {31'd0, busy}, 32'd1);
    wait_idle(40);
    repeat (3) begin
      @(negedge clk);
      chk("t5_blocked_gnt", {28'd0, gnt}, 32'd0);
      chk("t5_blocked_busy", {31'd0, busy}, 32'd0);
    end
    fifo_full = 1'b0;
    @(negedge clk);
    chk("t5_next_gnt", {28'd0, gnt}, 32'h1);
    chk("t5_next_adrs", {24'd0, memadrs}, 32'hCD);
    req = '0;
    wait_idle(40);
`else
    // Requester 0 pre-empts the rotation whenever it asks; 1..3 rotate otherwise.
    do_reset();
    begin
      logic p0[7];
      logic [3:0] eg[7];
      p0 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      eg = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b0010};
      for (int i = 0; i < 7; i++) begin
        req = {3'b111, p0[i]};
        @(negedge clk);
        chk($sformatf("t6_gnt%0d", i), {28'd0, gnt}, {28'd0, eg[i]});
        req[0] = 1'b0;
        wait_idle(40);
      end
    end
    req = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
